// File: rtl/gate_bist_ctrl_if.sv
// Control/result bundle between a gate BIST sequencer and the test logic that drives it.
// The gate output under test also travels on this bundle.
interface gate_bist_ctrl_if #(
   parameter int N_IN = 2
);
   logic            start;
   logic            abort;
   logic            gate_y;
   logic [N_IN-1:0] vec_out;
   logic            busy;
   logic            done;
   logic            pass;
   logic [N_IN:0]   err_count;
   logic            fail_valid;
   logic [N_IN-1:0] fail_vec;

   modport master (
      output start, abort, gate_y,
      input  vec_out, busy, done, pass, err_count, fail_valid, fail_vec
   );

   modport slave (
      input  start, abort, gate_y,
      output vec_out, busy, done, pass, err_count, fail_valid, fail_vec
   );
endinterface

// File: rtl/gate_bist_ctrl.sv
// Exhaustive BIST sequencer for one combinational gate: steps every input vector,
// waits SETTLE cycles, samples gate_y against EXPECT and records the outcome.
module gate_bist_ctrl #(
   parameter int                      N_IN   = 2,
   parameter int                      SETTLE = 2,
   parameter logic [(1<<N_IN)-1:0]    EXPECT = 4'b1000
) (
   input logic              clk,
   input logic              rst_n,
   gate_bist_ctrl_if.slave  bus
);
   localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SETTLE,
      S_SAMPLE
   } state_t;

   state_t          r_state, w_state;
   logic [N_IN-1:0] r_idx, w_idx;
   logic [CW-1:0]   r_cnt, w_cnt;
   logic [N_IN-1:0] r_vec, w_vec;
   logic            r_busy, w_busy;
   logic            r_done, w_done;
   logic            r_pass, w_pass;
   logic [N_IN:0]   r_err, w_err;
   logic            r_fvalid, w_fvalid;
   logic [N_IN-1:0] r_fvec, w_fvec;
   logic            w_miss;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_idx    <= '0;
         r_cnt    <= '0;
         r_vec    <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_pass   <= 1'b0;
         r_err    <= '0;
         r_fvalid <= 1'b0;
         r_fvec   <= '0;
      end else begin
         r_state  <= w_state;
         r_idx    <= w_idx;
         r_cnt    <= w_cnt;
         r_vec    <= w_vec;
         r_busy   <= w_busy;
         r_done   <= w_done;
         r_pass   <= w_pass;
         r_err    <= w_err;
         r_fvalid <= w_fvalid;
         r_fvec   <= w_fvec;
      end
   end

   always_comb begin
      w_state  = r_state;
      w_idx    = r_idx;
      w_cnt    = r_cnt;
      w_vec    = r_vec;
      w_busy   = r_busy;
      w_done   = 1'b0;
      w_pass   = r_pass;
      w_err    = r_err;
      w_fvalid = r_fvalid;
      w_fvec   = r_fvec;
      w_miss   = (bus.gate_y != EXPECT[r_idx]);

      // abort outranks settle/sample work but leaves partial results visible
      if (r_busy && bus.abort) begin
         w_state = S_IDLE;
         w_busy  = 1'b0;
         w_vec   = '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  w_idx    = '0;
                  w_vec    = '0;
                  w_cnt    = '0;
                  w_err    = '0;
                  w_fvalid = 1'b0;
                  w_fvec   = '0;
                  w_busy   = 1'b1;
                  w_state  = S_SETTLE;
               end
            end
            S_SETTLE: begin
               w_cnt = r_cnt + 1'b1;
               if (r_cnt == CNT_LAST) w_state = S_SAMPLE;
            end
            S_SAMPLE: begin
               if (w_miss) begin
                  w_err = r_err + 1'b1;
                  if (!r_fvalid) begin
                     w_fvalid = 1'b1;
                     w_fvec   = r_idx;
                  end
               end
               if (r_idx != '1) begin
                  w_idx   = r_idx + 1'b1;
                  w_vec   = r_idx + 1'b1;
                  w_cnt   = '0;
                  w_state = S_SETTLE;
               end else begin
                  // pass reflects the error total including this last sample
                  w_done  = 1'b1;
                  w_busy  = 1'b0;
                  w_pass  = (w_err == '0);
                  w_vec   = '0;
                  w_state = S_IDLE;
               end
            end
            default: w_state = S_IDLE;
         endcase
      end
   end

   assign bus.vec_out    = r_vec;
   assign bus.busy       = r_busy;
   assign bus.done       = r_done;
   assign bus.pass       = r_pass;
   assign bus.err_count  = r_err;
   assign bus.fail_valid = r_fvalid;
   assign bus.fail_vec   = r_fvec;
endmodule

// File: tb/tb_gate_bist_ctrl.sv
// Randomized self-checking bench for gate_bist_ctrl: a gate truth table drives gate_y,
// and expected results come from comparing whole tables against the golden one.
module tb_gate_bist_ctrl;
   localparam int N_IN = 2;
   localparam logic [3:0] AND_TT  = 4'b1000;
   localparam logic [3:0] NAND_TT = 4'b0111;

   logic clk = 1'b0;
   logic rst_n;
   logic [3:0] tbl_a, tbl_b;
   int   total = 0;
   int   bad   = 0;
   bit   exp_pass_a = 1'b0;

   always #5 clk = ~clk;

   gate_bist_ctrl_if #(.N_IN(N_IN)) ifa ();
   gate_bist_ctrl_if #(.N_IN(N_IN)) ifb ();

   assign ifa.gate_y = tbl_a[ifa.vec_out];
   assign ifb.gate_y = tbl_b[ifb.vec_out];

   gate_bist_ctrl #(.N_IN(N_IN), .SETTLE(2), .EXPECT(AND_TT)) u_dut_a (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifa)
   );

   gate_bist_ctrl #(.N_IN(N_IN), .SETTLE(1), .EXPECT(AND_TT)) u_dut_b (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifb)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic int model_errs(input logic [3:0] tbl);
      int n = 0;
      for (int k = 0; k < 4; k++) if (tbl[k] != AND_TT[k]) n++;
      return n;
   endfunction

   function automatic int model_first(input logic [3:0] tbl);
      for (int k = 0; k < 4; k++) if (tbl[k] != AND_TT[k]) return k;
      return 0;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // full run on instance A; edge 0 is the start edge, done expected after edge 12
   task automatic run_a(input logic [3:0] tbl, input bit poke, input bit abort_idle);
      int errs, first;
      errs  = model_errs(tbl);
      first = model_first(tbl);
      @(negedge clk);
      tbl_a     = tbl;
      ifa.start = 1'b1;
      ifa.abort = abort_idle;
      tick();
      ifa.start = 1'b0;
      ifa.abort = 1'b0;
      check("start_busy", ifa.busy, 1);
      check("start_vec", ifa.vec_out, 0);
      check("start_err_clr", ifa.err_count, 0);
      check("start_fv_clr", ifa.fail_valid, 0);
      check("start_pass_held", ifa.pass, exp_pass_a);
      for (int e = 1; e <= 12; e++) begin
         if (poke && (e == 5 || e == 9)) begin
            @(negedge clk);
            ifa.start = 1'b1;
         end
         tick();
         ifa.start = 1'b0;
         if (e < 12) begin
            check("run_vec", ifa.vec_out, e / 3);
            check("run_busy", ifa.busy, 1);
            check("run_no_done", ifa.done, 0);
         end else begin
            check("end_done", ifa.done, 1);
            check("end_busy", ifa.busy, 0);
            check("end_vec", ifa.vec_out, 0);
            check("end_err", ifa.err_count, errs);
            check("end_fv", ifa.fail_valid, errs != 0);
            if (errs != 0) check("end_fvec", ifa.fail_vec, first);
            check("end_pass", ifa.pass, errs == 0);
         end
      end
      exp_pass_a = (errs == 0);
      tick();
      check("done_pulse_1cyc", ifa.done, 0);
      check("pass_hold", ifa.pass, exp_pass_a);
   endtask

   initial begin
      rst_n     = 1'b0;
      tbl_a     = AND_TT;
      tbl_b     = AND_TT;
      ifa.start = 1'b0;
      ifa.abort = 1'b0;
      ifb.start = 1'b0;
      ifb.abort = 1'b0;
      #12;
      check("rst_busy", ifa.busy, 0);
      check("rst_done", ifa.done, 0);
      check("rst_pass", ifa.pass, 0);
      check("rst_vec", ifa.vec_out, 0);
      check("rst_err", ifa.err_count, 0);
      check("rst_fv", ifa.fail_valid, 0);
      check("rst_fvec", ifa.fail_vec, 0);
      @(negedge clk);
      rst_n = 1'b1;

      run_a(AND_TT, 1'b0, 1'b0);
      run_a(4'b0000, 1'b0, 1'b0);
      run_a(NAND_TT, 1'b0, 1'b0);
      run_a(AND_TT, 1'b0, 1'b0);
      run_a(AND_TT, 1'b1, 1'b1);

      // abort seen at edge 5 while vector 1 settles; only vector 0 has been sampled
      @(negedge clk);
      tbl_a     = NAND_TT;
      ifa.start = 1'b1;
      tick();
      ifa.start = 1'b0;
      for (int e = 1; e <= 4; e++) begin
         tick();
         check("ab_vec", ifa.vec_out, e / 3);
      end
      @(negedge clk);
      ifa.abort = 1'b1;
      tick();
      ifa.abort = 1'b0;
      check("ab_busy", ifa.busy, 0);
      check("ab_vec0", ifa.vec_out, 0);
      check("ab_no_done", ifa.done, 0);
      check("ab_err", ifa.err_count, 1);
      check("ab_fv", ifa.fail_valid, 1);
      check("ab_fvec", ifa.fail_vec, 0);
      check("ab_pass", ifa.pass, exp_pass_a);
      tick();
      check("ab_no_done2", ifa.done, 0);
      check("ab_idle", ifa.busy, 0);
      ifa.abort = 1'b1;
      tick();
      ifa.abort = 1'b0;
      check("ab_idle_noeff", ifa.err_count, 1);
      run_a(AND_TT, 1'b0, 1'b0);

      // asynchronous reset mid-SETTLE, between clock edges
      @(negedge clk);
      tbl_a     = AND_TT;
      ifa.start = 1'b1;
      tick();
      ifa.start = 1'b0;
      tick();
      tick();
      tick();
      tick();
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("arst_busy", ifa.busy, 0);
      check("arst_vec", ifa.vec_out, 0);
      check("arst_pass", ifa.pass, 0);
      check("arst_done", ifa.done, 0);
      check("arst_err", ifa.err_count, 0);
      #1 rst_n = 1'b1;
      exp_pass_a = 1'b0;
      for (int e = 0; e < 14; e++) begin
         tick();
         check("arst_no_done", ifa.done, 0);
      end

      for (int i = 0; i < 8; i++) begin
         logic [3:0] t;
         t = 4'($urandom_range(0, 15));
         run_a(t, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end

      // SETTLE=1 with start held: done after edges 8, 17, 26
      @(negedge clk);
      tbl_b     = AND_TT;
      ifb.start = 1'b1;
      for (int e = 0; e <= 26; e++) begin
         tick();
         check("b2b_done", ifb.done, (e == 8 || e == 17 || e == 26));
         if (e == 8 || e == 17 || e == 26) begin
            check("b2b_pass", ifb.pass, 1);
            check("b2b_err", ifb.err_count, 0);
         end
      end
      ifb.start = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/gate_bist_ctrl.md
Name: gate_bist_ctrl

Overview:
- Built-in self-test sequencer for a single combinational gate cell, such as the switch-level 2-input AND.
- Drives every input vector onto the gate's inputs in ascending order and waits a programmable settle time.
- Samples the gate output and compares it with an expected truth table.
- Reports pass/fail, the mismatch count and the first failing vector.
- Sits between the gate-level cells and the bench/top-level test logic; one instance exercises one gate.

Parameters:
- N_IN, 2, number of gate inputs; vectors run 0 .. 2^N_IN-1.
- SETTLE, 2, cycles the vector is held before sampling; legal range >= 1.
- EXPECT, 4'b1000, expected truth table, 2^N_IN bits wide. Bit k is the expected output for input vector k (default is AND: only vector 2'b11 gives 1).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin a test run; sampled only in IDLE.
- abort  input  1  synchronous cancel of a run in progress.
- vec_out  output  N_IN  input vector driven to the gate; bit 0 goes to the first gate input (a).
- gate_y  input  1  gate output under test.
- busy  output  1  high while a run is in progress.
- done  output  1  one-cycle pulse at run completion; not pulsed on abort.
- pass  output  1  1 when the last completed run had zero mismatches; held until the next completion.
- err_count  output  N_IN+1  mismatches in the current or last run; saturation not needed because max = 2^N_IN.
- fail_valid  output  1  at least one mismatch captured in the current or last run.
- fail_vec  output  N_IN  first mismatching vector; valid only when fail_valid=1.

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous, active-low. All state is registered.
- Reset values: state=IDLE, vec_out=0, busy=0, done=0, pass=0, err_count=0, fail_valid=0, fail_vec=0, internal idx=0, settle counter cnt=0.
- IDLE:
  - start=1 at an edge causes, at that edge: idx=0, vec_out=0, cnt=0, err_count=0, fail_valid=0, fail_vec=0, busy=1, state=SETTLE.
  - pass is not cleared at start.
- SETTLE: cnt increments each edge. When cnt==SETTLE-1, state goes to SAMPLE at that edge.
- SAMPLE (one cycle) compares gate_y with EXPECT[idx].
  - On mismatch: err_count+1. If fail_valid=0, set fail_valid=1 and fail_vec=idx.
  - If idx < 2^N_IN-1: idx+1, vec_out=idx+1, cnt=0, state=SETTLE.
  - If idx == 2^N_IN-1: done=1 for one cycle, busy=0, pass=(final err_count==0), vec_out=0, state=IDLE. The final err_count includes this sample.
- Timing:
  - Each vector occupies SETTLE+1 cycles.
  - done is high in the cycle after edge number 2^N_IN*(SETTLE+1), counting the start edge as edge 0. For the defaults, done rises at edge 12.
  - Earliest restart is the edge after done; start held high gives back-to-back runs with a period of 2^N_IN*(SETTLE+1)+1 cycles.
- Priority and ignore rules:
  - start while busy is ignored.
  - abort has priority over the SETTLE/SAMPLE actions: at the edge it is seen with busy=1, go to IDLE, busy=0, vec_out=0, done stays 0, and err_count/fail_* hold their partial values. pass is unchanged.
  - abort in IDLE has no effect. If start and abort are both high in IDLE, start wins; abort is only evaluated while busy.
- Reset mid-run: immediate return to all reset values, independent of clk. No done pulse is produced.
- vec_out changes only on the edge that enters a vector's SETTLE, so it is stable throughout SETTLE and SAMPLE.

Test Plan:
- Defaults with a correct AND gate connected, start pulsed at edge 0 -> vec_out steps 00,01,10,11 every 3 cycles; done pulses at edge 12; pass=1, err_count=0, fail_valid=0; vec_out returns to 00.
- Gate output stuck at 0 -> done at edge 12; err_count=1, fail_valid=1, fail_vec=2'b11, pass=0.
- NAND substituted for AND -> err_count=4, fail_vec=2'b00, pass=0. A following correct-AND run clears err_count at start and ends with pass=1.
- abort asserted at edge 5 (vector 01 settling) -> busy=0 and vec_out=00 at edge 5; no done pulse; err_count holds its partial value. start at edge 7 runs a full test normally.
- rst_n pulsed low mid-SETTLE between clock edges -> all outputs reach reset values immediately. start pulses during the run are ignored while busy=1.
- SETTLE=1, start held high continuously -> done pulses at edges 8, 17, 26 (period 9); every run reports pass=1 with a correct AND.
